int_sqrt_engine: RTL
====================

# int_sqrt_engine

Parametrised integer square-root unit. It computes floor(sqrt(X)) and the remainder X − root² for a W-bit unsigned operand, with an optional round-to-nearest mode. It uses a restoring digit-by-digit recurrence that resolves one root bit per clock, so latency is fixed at W/2+1 cycles. It sits behind a start/busy/done handshake and drops in where the fixed 8-bit odd-number-summing calculator was used.

## Interface
- W, 8: operand width; must be even and ≥ 4. Root width R = W/2.
- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clock.
- S  in  1  start request; honoured only in IDLE.
- Mode  in  1  captured with S: 0 = floor result, 1 = round-to-nearest.
- X  in  W  unsigned operand, captured on the accepting edge.
- sqrt  out  R  result root, registered, held until the next Done.
- rem  out  R+1  X − floor(sqrt(X))², always the floor remainder (range 0..2·root).
- Busy  out  1  high while a computation is in flight (CALC and FIN).
- Done  out  1  single-cycle pulse: sqrt and rem updated this cycle.

## Operation
- FSM states: IDLE, CALC, FIN.
- IDLE: on S=1, load the operand shift register with X, clear the partial root and partial remainder, load the iteration counter with R−1, latch Mode, and go to CALC.
- CALC: one iteration per edge.
  - Shift the next 2 MSBs of the operand into the remainder: t = (remp·4 + bits) − (rootp·4 + 1).
  - If t ≥ 0: remp = t, rootp = rootp·2 + 1. Otherwise remp = remp·4 + bits, rootp = rootp·2.
  - Remainder datapath is R+2 bits signed. No other widening is needed.
  - When the counter reaches 0, go to FIN; otherwise decrement the counter.
- FIN: register the results and return to IDLE.
  - rem = remp.
  - sqrt = rootp in floor mode.
  - In round mode, sqrt = rootp+1 if remp > rootp, else rootp. This is exact because x ≥ r²+r+1 iff sqrt(x) > r+0.5.
  - Round mode saturates: if rootp = 2^R−1 and rounding would overflow, sqrt = 2^R−1.
  - Done = 1 for that one cycle.
- S while Busy=1 is ignored. It is not queued and does not disturb the running job.
- X and Mode are don't-care except on the accepting edge.

## Timing
- Reset values: sqrt = 0, rem = 0, Busy = 0, Done = 0, FSM = IDLE, counter and datapath = 0.
- Accept edge E0 (IDLE, S=1): Busy = 1 from E0.
- Iteration edges are E1..E_R. FSM enters FIN after E_R.
- Edge E_{R+1}: sqrt and rem registered, Done = 1, Busy = 0, FSM = IDLE.
- Latency from S sampled to Done visible is R+1 edges: 5 for W=8, 9 for W=16.
- Back-to-back operation: S may be high in the Done cycle and is accepted on the next edge. Throughput is one result per R+2 cycles.
- Reset asserted at any edge:
  - Reset has priority over S.
  - An in-flight job is abandoned with no Done pulse.
  - Outputs return to their reset values on that edge.
- Done is never asserted for two consecutive cycles.
- Busy and Done are never high together.

## Test plan
- W=8, Mode=0, X=0 → after 5 edges: Done pulse, sqrt=0, rem=0. X=1 → sqrt=1, rem=0.
- W=8, Mode=0, X=255 → sqrt=15, rem=30. Mode=1, X=255 → sqrt=15 (saturated), rem=30.
- W=8, Mode=1: X=143 → sqrt=12, rem=22. X=132 → sqrt=11, rem=11 (boundary case: remp = rootp does not round up). X=144 → sqrt=12, rem=0.
- W=8: pulse S with X=100, then hold S=1 with X=200 during Busy → single Done with sqrt=10. Then a back-to-back start in the Done cycle with X=200 → sqrt=14, rem=4 exactly 6 cycles after the first Done.
- W=8: start X=99, assert Reset at E3 → no Done, all outputs 0 next cycle. Then a new start with X=99 → sqrt=9, rem=18. Also: S and Reset high on the same edge → stays IDLE.
- W=16, all X in 0..65535 plus both Modes, checked against a reference model.
  - Spot check: X=65535 → sqrt=255, rem=510, Done 9 edges after start.
  - Every result must satisfy sqrt² + rem = X and rem ≤ 2·sqrt in floor mode.

Source files
------------

// File: rtl/int_sqrt_engine_if.sv
// Start/busy/done handshake bundle for the integer square-root engine.
// The requester (master) drives the operand and start; the engine (slave) returns the result.
interface int_sqrt_engine_if #(
    parameter int W = 8
);
    localparam int R = W / 2;

    logic         S;
    logic         Mode;
    logic [W-1:0] X;
    logic [R-1:0] sqrt;
    logic [R:0]   rem;
    logic         Busy;
    logic         Done;

    modport master (
        output S, Mode, X,
        input  sqrt, rem, Busy, Done
    );

    modport slave (
        input  S, Mode, X,
        output sqrt, rem, Busy, Done
    );
endinterface

// File: rtl/int_sqrt_engine.sv
// Restoring digit-by-digit integer square root: one root bit per clock, W/2+1 cycles
// per result, with floor or round-to-nearest (saturating) output.
module int_sqrt_engine #(
    parameter int W = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    int_sqrt_engine_if.slave  bus
);
    localparam int R  = W / 2;
    localparam int CW = (R > 2) ? $clog2(R) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   opnd_q;
    logic [R-1:0]   root_q;
    logic [R+1:0]   remp_q;
    logic [CW-1:0]  cnt_q;
    logic           mode_q;
    logic [R-1:0]   sqrt_q;
    logic [R:0]     rem_q;
    logic           done_q;

    logic [R+1:0]   shifted;
    logic [R+1:0]   trial;
    logic [R-1:0]   rounded;

    // The true trial value always lies within R+2 signed bits, so modular
    // subtraction gives an exact sign bit without any extra widening.
    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        shifted = {remp_q[R-1:0], opnd_q[W-1 -: 2]};
        trial   = shifted - {root_q, 2'b01};
        rounded = root_q;
        if (remp_q > {2'b00, root_q} && !(&root_q)) begin
            rounded = root_q + R'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.S) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all registered state uses non-blocking assignments so every flop
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            root_q  <= '0;
            remp_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            sqrt_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.S) begin
                        opnd_q <= bus.X;
                        root_q <= '0;
                        remp_q <= '0;
                        cnt_q  <= CW'(R - 1);
                        mode_q <= bus.Mode;
                    end
                end
                CALC: begin
                    opnd_q <= opnd_q << 2;
                    if (!trial[R+1]) begin
                        remp_q <= trial;
                        root_q <= {root_q[R-2:0], 1'b1};
                    end else begin
                        remp_q <= shifted;
                        root_q <= {root_q[R-2:0], 1'b0};
                    end
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                FIN: begin
                    rem_q  <= remp_q[R:0];
                    sqrt_q <= mode_q ? rounded : root_q;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.sqrt = sqrt_q;
    assign bus.rem  = rem_q;
    assign bus.Done = done_q;
    assign bus.Busy = (state_q != IDLE);
endmodule
